// File: rtl/bus_arbiter_4x1.sv
// Four-requester round-robin bus arbiter with a single-word handshake per grant.
// A grant ends on transfer, withdrawal or wait timeout; one IDLE cycle always follows.
module bus_arbiter_4x1 #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [3:0]  ack,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  ack_q, ack_d;
    logic        timeout_q, timeout_d;
    logic [1:0]  win;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                win = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        ack_d     = 4'b0000;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req != 4'b0000) begin
                    sel_d   = win;
                    grant_d = 4'b0001 << win;
                    cnt_d   = 8'd0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // Withdrawal wins over transfer.
                if (!req[sel_q]) begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                end else if (out_ready) begin
                    state_d = StIdle;
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                    ack_d   = 4'b0001 << sel_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == 8'(MAX_WAIT - 1)) begin
                        state_d   = StIdle;
                        grant_d   = 4'b0000;
                        ptr_d     = sel_q + 2'd1;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= 2'd0;
            sel_q     <= 2'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 4'b0000;
            ack_q     <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        out_data = 16'h0000;
        if (state_q == StGrant) begin
            unique case (sel_q)
                2'd0: out_data = in0;
                2'd1: out_data = in1;
                2'd2: out_data = in2;
                2'd3: out_data = in3;
                default: out_data = 16'h0000;
            endcase
        end
    end

    assign out_valid = (state_q == StGrant);
    assign busy      = (state_q == StGrant);
    assign grant     = grant_q;
    assign sel       = sel_q;
    assign ack       = ack_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// Bench for bus_arbiter_4x1: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration rules.
module tb_bus_arbiter_4x1;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] din [4];
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic [3:0]  ack;
    logic        timeout;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner of the bus (or none), rotating priority start, waited cycles.
    bit       m_busy;
    int       m_sel;
    int       m_ptr;
    int       m_wait;
    bit [3:0] m_ack;
    bit       m_to;

    always #5 clk = ~clk;

    bus_arbiter_4x1 #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (din[0]),
        .in1       (din[1]),
        .in2       (din[2]),
        .in3       (din[3]),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .grant     (grant),
        .sel       (sel),
        .ack       (ack),
        .timeout   (timeout),
        .busy      (busy)
    );

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_wait = 0; m_ack = 0; m_to = 0;
    endtask

    task automatic model_release();
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 4;
    endtask

    task automatic model_edge();
        m_ack = 0;
        m_to  = 0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req[(m_ptr + k) % 4]) begin
                    m_sel  = (m_ptr + k) % 4;
                    m_busy = 1;
                    m_wait = 0;
                end
            end
        end else if (!req[m_sel]) begin
            model_release();
        end else if (out_ready) begin
            m_ack = 4'(1 << m_sel);
            model_release();
        end else begin
            m_wait++;
            if (m_wait >= MW) begin
                m_to = 1;
                model_release();
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 16'h1111 * 16'(i + 1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_err++; $display("FAIL reset_grant: got %b want 0000", grant);
        end
        n_cmp++;
        if ({out_valid, busy, ack, timeout} !== 7'b0) begin
            n_err++; $display("FAIL reset_flags: got %b want 0", {out_valid, busy, ack, timeout});
        end
        n_cmp++;
        if (out_data !== 16'h0000 || sel !== 2'd0) begin
            n_err++; $display("FAIL reset_data: got %h/%0d want 0000/0", out_data, sel);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b0110;
        out_ready = 1'b1;
        din[1] = 16'hA5A5;
        step();
        n_cmp++;
        if (grant !== 4'b0010 || out_data !== 16'hA5A5 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_grant: got %b/%h/%b want 0010/a5a5/1", grant, out_data, out_valid);
        end
        step();
        n_cmp++;
        if (ack !== 4'b0010 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL basic_ack: got ack %b grant %b busy %b want 0010/0000/0",
                              ack, grant, busy);
        end
        step();
        n_cmp++;
        if (grant !== 4'b0100 || ack !== 4'b0000) begin
            n_err++; $display("FAIL basic_next: got grant %b ack %b want 0100/0000", grant, ack);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [9];
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                    4'b1000, 4'b0000, 4'b0001};
        do_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            n_cmp++;
            if (grant !== exp_seq[i]) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_seq[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        out_ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            step();
            n_cmp++;
            if (grant !== 4'b0001 || timeout !== 1'b0 || ack !== 4'b0000) begin
                n_err++; $display("FAIL to_hold[%0d]: got grant %b to %b ack %b want 0001/0/0000",
                                  i, grant, timeout, ack);
            end
        end
        step();
        n_cmp++;
        if (timeout !== 1'b1 || grant !== 4'b0000 || ack !== 4'b0000) begin
            n_err++; $display("FAIL to_pulse: got to %b grant %b ack %b want 1/0000/0000",
                              timeout, grant, ack);
        end
        step();
        n_cmp++;
        if (timeout !== 1'b0 || grant !== 4'b0001) begin
            n_err++; $display("FAIL to_regrant: got to %b grant %b want 0/0001", timeout, grant);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0100;
        out_ready = 1'b0;
        step();
        req = 4'b0000;
        out_ready = 1'b1;
        step();
        n_cmp++;
        if (ack !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_err++; $display("FAIL wd_idle: got ack %b grant %b busy %b want 0000/0000/0",
                              ack, grant, busy);
        end
        req = 4'b1111;
        out_ready = 1'b0;
        step();
        n_cmp++;
        if (grant !== 4'b1000 || sel !== 2'd3) begin
            n_err++; $display("FAIL wd_ptr: got grant %b sel %0d want 1000/3", grant, sel);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0010;
        out_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({grant, ack, timeout, out_valid, busy, sel} !== 13'b0 || out_data !== 16'h0) begin
            n_err++; $display("FAIL midrst_outputs: got %b %h want all zero",
                              {grant, ack, timeout, out_valid, busy, sel}, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000;
        step();
        n_cmp++;
        if (grant !== 4'b1000 || ack !== 4'b0000 || timeout !== 1'b0) begin
            n_err++; $display("FAIL midrst_restart: got grant %b ack %b to %b want 1000/0000/0",
                              grant, ack, timeout);
        end
    endtask

    task automatic test_random();
        int beats [4];
        int acks  [4];
        int thr;
        logic [3:0]  exp_grant;
        logic [15:0] exp_data;
        for (int i = 0; i < 4; i++) begin beats[i] = 0; acks[i] = 0; end
        do_reset();
        for (int c = 0; c < 800; c++) begin
            step();
            thr = (c < 400) ? 7 : 1;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < thr);
            for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
            #1;
            exp_grant = m_busy ? 4'(1 << m_sel) : 4'b0000;
            exp_data  = m_busy ? din[m_sel] : 16'h0000;
            n_cmp++;
            if (grant !== exp_grant) begin
                n_err++; $display("FAIL rnd_grant@%0d: got %b want %b", c, grant, exp_grant);
            end
            n_cmp++;
            if ($countones(grant) > 1) begin
                n_err++; $display("FAIL rnd_onehot@%0d: got %b want at most one bit", c, grant);
            end
            n_cmp++;
            if (out_valid !== m_busy || busy !== m_busy || (m_busy && sel !== 2'(m_sel))) begin
                n_err++; $display("FAIL rnd_state@%0d: got v%b b%b sel%0d want %b/%0d",
                                  c, out_valid, busy, sel, m_busy, m_sel);
            end
            n_cmp++;
            if (out_data !== exp_data) begin
                n_err++; $display("FAIL rnd_data@%0d: got %h want %h", c, out_data, exp_data);
            end
            n_cmp++;
            if (ack !== m_ack || timeout !== m_to || (ack != 4'b0 && timeout)) begin
                n_err++; $display("FAIL rnd_pulse@%0d: got ack %b to %b want %b/%b",
                                  c, ack, timeout, m_ack, m_to);
            end
            for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) acks[i]++;
            if (out_valid === 1'b1 && out_ready && req[sel]) beats[sel]++;
        end
        step();
        for (int i = 0; i < 4; i++) if (ack[i] === 1'b1) acks[i]++;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (acks[i] != beats[i]) begin
                n_err++; $display("FAIL rnd_beats[%0d]: got %0d acks want %0d beats",
                                  i, acks[i], beats[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_reset_mid_grant();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter_4x1.md
BUS_ARBITER_4X1 -- requirements
Module: bus_arbiter_4x1

Interface
REQ-001 Parameter: MAX_WAIT, default 15, range 1..255; maximum GRANT cycles without out_ready before the grant is aborted.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-requester request; bit i belongs to requester i.
REQ-005 Port: in0, in1, in2, in3  input  16 each  requester data words.
REQ-006 Port: out_ready  input  1  consumer accepts out_data this cycle.
REQ-007 Port: out_data  output  16  selected requester word.
REQ-008 Port: out_valid  output  1  out_data is valid.
REQ-009 Port: grant  output  4  one-hot grant; all zero when not granting.
REQ-010 Port: sel  output  2  index of the current or last granted requester.
REQ-011 Port: ack  output  4  one-cycle pulse per requester marking a completed transfer.
REQ-012 Port: timeout  output  1  one-cycle pulse marking an aborted grant.
REQ-013 Port: busy  output  1  high while in GRANT.

Function
REQ-014 The state machine SHALL have two states: IDLE and GRANT.
REQ-015 Priority pointer ptr[1:0]: search order is ptr, ptr+1, ptr+2, ptr+3, all modulo 4.
REQ-016 IDLE with req != 0 SHALL register the winner into sel, set grant one-hot, clear the wait counter and enter GRANT on the next edge.
REQ-017 IDLE with req == 0: state, sel and ptr SHALL hold.
REQ-018 GRANT: out_valid = 1, busy = 1, grant = onehot(sel).
REQ-019 out_data is combinational: in[sel] in GRANT, 16'h0000 otherwise.
REQ-020 GRANT with out_ready = 1 and req[sel] = 1 is a transfer.
  - Next edge: ack[sel] = 1 for exactly one cycle, ptr = sel+1 (wraps 3 to 0), return to IDLE.
REQ-021 GRANT with req[sel] = 0 (regardless of out_ready) is a withdrawal.
  - Return to IDLE, no ack, ptr = sel+1.
  - Withdrawal SHALL take precedence over transfer.
REQ-022 GRANT with out_ready = 0 and req[sel] = 1: the 8-bit wait counter SHALL increment.
  - When the counter equals MAX_WAIT-1 on such a cycle: next edge pulses timeout for one cycle, ptr = sel+1, return to IDLE, no ack.
REQ-023 Requests from non-granted requesters during GRANT SHALL be ignored; no preemption.
REQ-024 Latency:
  - Request seen in IDLE at edge N gives out_valid high after edge N.
  - Minimum transfer spacing is 2 cycles, because one IDLE cycle always follows GRANT.
REQ-025 ack, timeout and grant SHALL be registered; ack and timeout SHALL never be high in the same cycle.
REQ-026 At most one ack bit SHALL be high in any cycle.

Reset
REQ-027 rst_n low SHALL immediately force:
  - state IDLE, ptr = 0, sel = 0, counter = 0
  - grant = 0, ack = 0, timeout = 0, out_valid = 0, busy = 0, out_data = 0
REQ-028 Reset asserted during GRANT SHALL abort the transfer with no ack and no timeout.
  - After release, arbitration restarts from ptr = 0.
REQ-029 The first arbitration SHALL occur on the first rising edge with rst_n high.

Verification
REQ-030 Reset release, then req = 4'b0110, out_ready = 1, in1 = 16'hA5A5 -> grant = 0010, out_data = A5A5 for 1 cycle, then ack = 0010 for 1 cycle; next grant = 0100.
REQ-031 req = 4'b1111 held, out_ready = 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
REQ-032 req = 4'b0001, out_ready = 0, MAX_WAIT = 15 -> grant held 15 cycles, then timeout pulse, no ack; the next grant goes to requester 0 only after a full pointer wrap.
REQ-033 Requester 2 granted, req[2] dropped with out_ready = 1 in the same cycle -> no ack, return to IDLE, ptr = 3.
REQ-034 rst_n pulled low mid-GRANT with out_ready = 0 -> all outputs 0 immediately; after release with req = 4'b1000, grant = 1000 on the first edge.
REQ-035 out_ready toggled randomly with random req; a scoreboard checks:
  - one-hot grant
  - out_data == in[sel] while out_valid
  - acks match accepted beats
